// File: rtl/stall_ctrl.sv
// stall_ctrl: hazard detection and stall control for a 5-stage MIPS-style pipeline.
// Detects rs/rt data hazards from Tuse/Tnew timing and multiply/divide unit
// occupancy, then freezes PC and IF/ID while inserting a bubble into ID/EX.
// Optional feature: define STALL_CTRL_PERF_EN to build a 32-bit stall-cycle counter
// on StallCnt_o. Without it, the port is tied to zero and no counter flops exist.
module stall_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ID_Rs_i,
   input  logic [4:0]  ID_Rt_i,
   input  logic [1:0]  ID_TuseRs_i,
   input  logic [1:0]  ID_TuseRt_i,
   input  logic [4:0]  EX_RegAddr_i,
   input  logic [4:0]  MEM_RegAddr_i,
   input  logic [1:0]  EX_Tnew_i,
   input  logic [1:0]  MEM_Tnew_i,
   input  logic        ID_IsMD_i,
   input  logic        EX_MDStart_i,
   input  logic        EX_MDIsDiv_i,
   output logic        PC_en_o,
   output logic        IFID_en_o,
   output logic        IDEX_clr_o,
   output logic        Stall_o,
   output logic        MDBusy_o,
   output logic [31:0] StallCnt_o
);

   localparam logic [3:0] MULT_CYCLES = 4'd5;
   localparam logic [3:0] DIV_CYCLES  = 4'd10;

   logic [3:0] r_md_cnt;
   logic       w_stall_rs;
   logic       w_stall_rt;
   logic       w_data_stall;
   logic       w_md_busy;
   logic       w_md_stall;
   logic       w_stall;

   // A source operand is hazardous when a younger-needed value is not yet
   // forwardable. Register 0 never hazards, and Tuse=3 can never be below Tnew.
   function automatic logic operand_hazard(
      input logic [4:0] src,
      input logic [1:0] tuse,
      input logic [4:0] ex_dst,
      input logic [1:0] ex_tnew,
      input logic [4:0] mem_dst,
      input logic [1:0] mem_tnew
   );
      logic w_ex_hit;
      logic w_mem_hit;
      w_ex_hit  = (src == ex_dst)  && (tuse < ex_tnew);
      w_mem_hit = (src == mem_dst) && (tuse < mem_tnew);
      return (src != 5'd0) && (w_ex_hit || w_mem_hit);
   endfunction

   // Combinational hazard evaluation; stall takes effect in the same cycle.
   always_comb begin
      w_stall_rs   = operand_hazard(ID_Rs_i, ID_TuseRs_i, EX_RegAddr_i, EX_Tnew_i,
                                    MEM_RegAddr_i, MEM_Tnew_i);
      w_stall_rt   = operand_hazard(ID_Rt_i, ID_TuseRt_i, EX_RegAddr_i, EX_Tnew_i,
                                    MEM_RegAddr_i, MEM_Tnew_i);
      w_data_stall = w_stall_rs | w_stall_rt;
      // A start pulse counts as busy immediately, before the counter is loaded.
      w_md_busy    = (r_md_cnt != 4'd0) | EX_MDStart_i;
      w_md_stall   = ID_IsMD_i & w_md_busy;
      // Reset masks every stall indication so the pipeline runs freely.
      w_stall      = ~reset & (w_data_stall | w_md_stall);
   end

   // Pipeline control outputs; ID/EX is never disabled, only cleared to a bubble.
   always_comb begin
      Stall_o    = w_stall;
      PC_en_o    = ~w_stall;
      IFID_en_o  = ~w_stall;
      IDEX_clr_o = w_stall;
      MDBusy_o   = ~reset & w_md_busy;
   end

   // Multiply/divide occupancy countdown; a new start reloads even mid-operation,
   // and the countdown proceeds independently of any pipeline stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_md_cnt <= 4'd0;
      end else if (EX_MDStart_i) begin
         r_md_cnt <= EX_MDIsDiv_i ? DIV_CYCLES : MULT_CYCLES;
      end else if (r_md_cnt != 4'd0) begin
         r_md_cnt <= r_md_cnt - 4'd1;
      end
   end

`ifdef STALL_CTRL_PERF_EN
   logic [31:0] r_stall_cnt;

   // Cumulative stall-cycle counter; wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= 32'd0;
      end else if (w_stall) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign StallCnt_o = r_stall_cnt;
`else
   assign StallCnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed testbench for stall_ctrl. Inputs change just after the falling edge
// and outputs are sampled 1 time unit later, well away from the rising edge.
module tb_stall_ctrl;

   logic        clk;
   logic        reset;
   logic [4:0]  ID_Rs_i;
   logic [4:0]  ID_Rt_i;
   logic [1:0]  ID_TuseRs_i;
   logic [1:0]  ID_TuseRt_i;
   logic [4:0]  EX_RegAddr_i;
   logic [4:0]  MEM_RegAddr_i;
   logic [1:0]  EX_Tnew_i;
   logic [1:0]  MEM_Tnew_i;
   logic        ID_IsMD_i;
   logic        EX_MDStart_i;
   logic        EX_MDIsDiv_i;
   logic        PC_en_o;
   logic        IFID_en_o;
   logic        IDEX_clr_o;
   logic        Stall_o;
   logic        MDBusy_o;
   logic [31:0] StallCnt_o;

   int total;
   int bad;

`ifdef STALL_CTRL_PERF_EN
   localparam logic [31:0] EXP_CNT7 = 32'd7;
`else
   localparam logic [31:0] EXP_CNT7 = 32'd0;
`endif

   stall_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .ID_Rs_i       (ID_Rs_i),
      .ID_Rt_i       (ID_Rt_i),
      .ID_TuseRs_i   (ID_TuseRs_i),
      .ID_TuseRt_i   (ID_TuseRt_i),
      .EX_RegAddr_i  (EX_RegAddr_i),
      .MEM_RegAddr_i (MEM_RegAddr_i),
      .EX_Tnew_i     (EX_Tnew_i),
      .MEM_Tnew_i    (MEM_Tnew_i),
      .ID_IsMD_i     (ID_IsMD_i),
      .EX_MDStart_i  (EX_MDStart_i),
      .EX_MDIsDiv_i  (EX_MDIsDiv_i),
      .PC_en_o       (PC_en_o),
      .IFID_en_o     (IFID_en_o),
      .IDEX_clr_o    (IDEX_clr_o),
      .Stall_o       (Stall_o),
      .MDBusy_o      (MDBusy_o),
      .StallCnt_o    (StallCnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      ID_Rs_i       = 5'd0;
      ID_Rt_i       = 5'd0;
      ID_TuseRs_i   = 2'd3;
      ID_TuseRt_i   = 2'd3;
      EX_RegAddr_i  = 5'd0;
      MEM_RegAddr_i = 5'd0;
      EX_Tnew_i     = 2'd0;
      MEM_Tnew_i    = 2'd0;
      ID_IsMD_i     = 1'b0;
      EX_MDStart_i  = 1'b0;
      EX_MDIsDiv_i  = 1'b0;
   endtask

   task automatic test_reset();
      // Reset held with a hazard and a start pulse present: outputs forced idle.
      @(negedge clk);
      reset = 1'b1;
      ID_Rs_i = 5'd5; ID_TuseRs_i = 2'd0; EX_RegAddr_i = 5'd5; EX_Tnew_i = 2'd2;
      ID_IsMD_i = 1'b1; EX_MDStart_i = 1'b1; EX_MDIsDiv_i = 1'b1;
      #1;
      total++; if (Stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", Stall_o); end
      total++; if (PC_en_o !== 1'b1) begin bad++; $display("FAIL rst_pc_en got=%b want=1", PC_en_o); end
      total++; if (IFID_en_o !== 1'b1) begin bad++; $display("FAIL rst_ifid_en got=%b want=1", IFID_en_o); end
      total++; if (IDEX_clr_o !== 1'b0) begin bad++; $display("FAIL rst_idex_clr got=%b want=0", IDEX_clr_o); end
      total++; if (MDBusy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", MDBusy_o); end
      // Reset edge overrides the simultaneous start: counter stays 0.
      @(negedge clk);
      reset = 1'b0;
      clear_inputs();
      #1;
      total++; if (MDBusy_o !== 1'b0) begin bad++; $display("FAIL rst_after_busy got=%b want=0", MDBusy_o); end
      total++; if (Stall_o !== 1'b0) begin bad++; $display("FAIL rst_after_stall got=%b want=0", Stall_o); end
      total++; if (StallCnt_o !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", StallCnt_o); end
   endtask

   task automatic test_load_use();
      @(negedge clk);
      ID_Rs_i = 5'd5; ID_TuseRs_i = 2'd0; EX_RegAddr_i = 5'd5; EX_Tnew_i = 2'd2;
      #1;
      total++; if (Stall_o !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b want=1", Stall_o); end
      total++; if (PC_en_o !== 1'b0) begin bad++; $display("FAIL lu_pc_en got=%b want=0", PC_en_o); end
      total++; if (IFID_en_o !== 1'b0) begin bad++; $display("FAIL lu_ifid_en got=%b want=0", IFID_en_o); end
      total++; if (IDEX_clr_o !== 1'b1) begin bad++; $display("FAIL lu_idex_clr got=%b want=1", IDEX_clr_o); end
      EX_Tnew_i = 2'd0;
      #1;
      total++; if (Stall_o !== 1'b0) begin bad++; $display("FAIL lu_tnew0 got=%b want=0", Stall_o); end
      // Equal Tuse and Tnew is forwardable in time.
      ID_TuseRs_i = 2'd1; EX_Tnew_i = 2'd1;
      #1;
      total++; if (Stall_o !== 1'b0) begin bad++; $display("FAIL lu_equal got=%b want=0", Stall_o); end
      // rt hazard against MEM stage.
      @(negedge clk);
      clear_inputs();
      ID_Rt_i = 5'd7; ID_TuseRt_i = 2'd0; MEM_RegAddr_i = 5'd7; MEM_Tnew_i = 2'd1;
      #1;
      total++; if (Stall_o !== 1'b1) begin bad++; $display("FAIL mem_rt got=%b want=1", Stall_o); end
      // Different register, no hazard.
      MEM_RegAddr_i = 5'd8;
      #1;
      total++; if (Stall_o !== 1'b0) begin bad++; $display("FAIL mem_other got=%b want=0", Stall_o); end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_reg0();
      @(negedge clk);
      ID_Rt_i = 5'd0; ID_TuseRt_i = 2'd0; MEM_RegAddr_i = 5'd0; MEM_Tnew_i = 2'd1;
      #1;
      total++; if (Stall_o !== 1'b0) begin bad++; $display("FAIL reg0_mem got=%b want=0", Stall_o); end
      ID_Rs_i = 5'd0; ID_TuseRs_i = 2'd0; EX_RegAddr_i = 5'd0; EX_Tnew_i = 2'd3;
      #1;
      total++; if (Stall_o !== 1'b0) begin bad++; $display("FAIL reg0_ex got=%b want=0", Stall_o); end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_tuse3();
      @(negedge clk);
      ID_Rs_i = 5'd9; ID_TuseRs_i = 2'd3; EX_RegAddr_i = 5'd9; EX_Tnew_i = 2'd3;
      ID_Rt_i = 5'd9; ID_TuseRt_i = 2'd3; MEM_RegAddr_i = 5'd9; MEM_Tnew_i = 2'd3;
      #1;
      total++; if (Stall_o !== 1'b0) begin bad++; $display("FAIL tuse3 got=%b want=0", Stall_o); end
      ID_TuseRt_i = 2'd2;
      #1;
      total++; if (Stall_o !== 1'b1) begin bad++; $display("FAIL tuse2 got=%b want=1", Stall_o); end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_mult();
      logic exp_s;
      @(negedge clk);
      EX_MDStart_i = 1'b1; EX_MDIsDiv_i = 1'b0; ID_IsMD_i = 1'b1;
      for (int i = 0; i <= 6; i++) begin
         if (i > 0) begin
            @(negedge clk);
            EX_MDStart_i = 1'b0;
         end
         #1;
         exp_s = (i <= 5);
         total++;
         if (Stall_o !== exp_s) begin
            bad++; $display("FAIL mult_stall T+%0d got=%b want=%b", i, Stall_o, exp_s);
         end
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_div();
      logic exp_b;
      @(negedge clk);
      EX_MDStart_i = 1'b1; EX_MDIsDiv_i = 1'b1; ID_IsMD_i = 1'b0;
      for (int i = 0; i <= 11; i++) begin
         if (i > 0) begin
            @(negedge clk);
            EX_MDStart_i = 1'b0;
         end
         #1;
         exp_b = (i <= 10);
         total++;
         if (MDBusy_o !== exp_b) begin
            bad++; $display("FAIL div_busy T+%0d got=%b want=%b", i, MDBusy_o, exp_b);
         end
         total++;
         if (Stall_o !== 1'b0) begin
            bad++; $display("FAIL div_stall T+%0d got=%b want=0", i, Stall_o);
         end
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      logic exp_b;
      // mult at T0, div at T0+3 reloads to 10: busy through T0+13, free at T0+14.
      @(negedge clk);
      EX_MDStart_i = 1'b1; EX_MDIsDiv_i = 1'b0;
      for (int i = 0; i <= 14; i++) begin
         if (i > 0) begin
            @(negedge clk);
            EX_MDStart_i = (i == 3);
            EX_MDIsDiv_i = (i == 3);
         end
         #1;
         exp_b = (i <= 13);
         total++;
         if (MDBusy_o !== exp_b) begin
            bad++; $display("FAIL b2b_busy T+%0d got=%b want=%b", i, MDBusy_o, exp_b);
         end
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_reset_mid_div();
      @(negedge clk);
      EX_MDStart_i = 1'b1; EX_MDIsDiv_i = 1'b1; ID_IsMD_i = 1'b1;
      #1;
      total++; if (Stall_o !== 1'b1) begin bad++; $display("FAIL rmd_stall_T got=%b want=1", Stall_o); end
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk);
         EX_MDStart_i = 1'b0;
         #1;
         total++;
         if (MDBusy_o !== 1'b1) begin
            bad++; $display("FAIL rmd_busy T+%0d got=%b want=1", i, MDBusy_o);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++; if (MDBusy_o !== 1'b0) begin bad++; $display("FAIL rmd_busy_in_rst got=%b want=0", MDBusy_o); end
      total++; if (Stall_o !== 1'b0) begin bad++; $display("FAIL rmd_stall_in_rst got=%b want=0", Stall_o); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++; if (MDBusy_o !== 1'b0) begin bad++; $display("FAIL rmd_busy_T4 got=%b want=0", MDBusy_o); end
      total++; if (Stall_o !== 1'b0) begin bad++; $display("FAIL rmd_stall_T4 got=%b want=0", Stall_o); end
      total++; if (StallCnt_o !== 32'd0) begin bad++; $display("FAIL rmd_cnt_T4 got=%0d want=0", StallCnt_o); end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_stall_count();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         ID_Rs_i = 5'd3; ID_TuseRs_i = 2'd0; EX_RegAddr_i = 5'd3; EX_Tnew_i = 2'd1;
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         clear_inputs();
      end
      #1;
      total++; if (StallCnt_o !== EXP_CNT7) begin bad++; $display("FAIL cnt7 got=%0d want=%0d", StallCnt_o, EXP_CNT7); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_load_use();
      test_reg0();
      test_tuse3();
      test_mult();
      test_div();
      test_back_to_back();
      test_reset_mid_div();
      test_stall_count();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports ID_Rs_i, ID_Rt_i  input  5 each  source register numbers of instruction in ID.
REQ-004 SHALL have ports ID_TuseRs_i, ID_TuseRt_i  input  2 each  cycles until ID needs rs/rt; 3 = operand unused.
REQ-005 SHALL have ports EX_RegAddr_i, MEM_RegAddr_i  input  5 each  destination register held in ID/EX and EX/MEM.
REQ-006 SHALL have ports EX_Tnew_i, MEM_Tnew_i  input  2 each  cycles until that stage's result is forwardable.
REQ-007 SHALL have port ID_IsMD_i  input  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-008 SHALL have port EX_MDStart_i  input  1  one-cycle pulse; mult/div present in EX this cycle.
REQ-009 SHALL have port EX_MDIsDiv_i  input  1  qualifies EX_MDStart_i: 1 = div, 0 = mult.
REQ-010 SHALL have ports PC_en_o, IFID_en_o  output  1 each  enable for PC and IF/ID registers.
REQ-011 SHALL have port IDEX_clr_o  output  1  driven into the ID/EX register's synchronous reset, inserting a bubble.
REQ-012 SHALL have port Stall_o  output  1  stall asserted this cycle.
REQ-013 SHALL have port MDBusy_o  output  1  multiply/divide unit busy.
REQ-014 SHALL have port StallCnt_o  output  32  cumulative stall cycles (see Configuration).

Function
REQ-015 SHALL compute a data stall combinationally: for each of rs, rt: reg!=0 and ((reg==EX_RegAddr_i and Tuse<EX_Tnew_i) or (reg==MEM_RegAddr_i and Tuse<MEM_Tnew_i)).
REQ-016 SHALL hold a 4-bit counter md_cnt; on EX_MDStart_i load 5 (mult) or 10 (div), else decrement if nonzero, else hold 0.
REQ-017 SHALL drive MDBusy_o = (md_cnt!=0) | EX_MDStart_i.
REQ-018 SHALL compute an MD stall = ID_IsMD_i & MDBusy_o.
REQ-019 SHALL drive Stall_o = data stall | MD stall, combinationally in the same cycle as its inputs (zero latency).
REQ-020 SHALL drive PC_en_o = IFID_en_o = ~Stall_o and IDEX_clr_o = Stall_o; ID/EX enable is never withheld.
REQ-021 SHALL reload md_cnt when EX_MDStart_i arrives while md_cnt!=0 (last start wins).
REQ-022 SHALL count md_cnt down regardless of Stall_o.
REQ-023 SHALL treat a register-0 match as no hazard, whatever the Tnew value.
REQ-024 SHALL treat Tuse=3 as never stalling, because Tnew <= 3.

Reset
REQ-025 SHALL clear md_cnt and StallCnt_o to 0 on a reset edge, overriding any simultaneous EX_MDStart_i.
REQ-026 SHALL force Stall_o=0, PC_en_o=1, IFID_en_o=1, IDEX_clr_o=0, MDBusy_o=0 while reset is high.
REQ-027 SHALL abandon any in-flight countdown when reset is asserted mid-operation; busy SHALL be 0 on the first cycle after reset.

Configuration
REQ-028 SHALL, with STALL_CTRL_PERF_EN defined, increment StallCnt_o by 1 on each edge where Stall_o=1 and reset=0, wrapping from 0xFFFFFFFF to 0.
REQ-029 SHALL, without STALL_CTRL_PERF_EN, keep the StallCnt_o port and tie it to constant 0, with no counter flops.

Verification
REQ-030 SHALL test load-use: ID_Rs=5, TuseRs=0; EX_RegAddr=5, EX_Tnew=2 -> Stall_o=1, PC_en_o=0, IDEX_clr_o=1 in that cycle; EX_Tnew=0 -> Stall_o=0.
REQ-031 SHALL test register 0: ID_Rt=0, TuseRt=0; MEM_RegAddr=0, MEM_Tnew=1 -> Stall_o=0.
REQ-032 SHALL test mult then mfhi: EX_MDStart_i=1, IsDiv=0 at cycle T; ID_IsMD_i held 1 -> Stall_o=1 for cycles T..T+5, 0 at T+6.
REQ-033 SHALL test div: start at T, IsDiv=1 -> MDBusy_o=1 for T..T+10, 0 at T+11; ID_IsMD_i=0 throughout -> Stall_o=0.
REQ-034 SHALL test reset mid-divide: reset at T+3 after a div start at T -> MDBusy_o=0 at T+4; with PERF_EN, StallCnt_o=0 at T+4.
REQ-035 SHALL test the counter with PERF_EN: 7 stall cycles then 3 free cycles -> StallCnt_o=7; without the macro -> StallCnt_o=0.
